// File: rtl/uart_tx_arb.sv
// Frame-level round-robin arbiter that multiplexes NUM_REQ byte producers onto one
// uart_tx byte stream, optionally prefixing each frame with a requester-ID header byte.
module uart_tx_arb #(
   parameter int         NUM_REQ        = 4,
   parameter bit         INSERT_ID      = 1'b1,
   parameter logic [7:0] ID_BASE        = 8'h80,
   parameter int         TIMEOUT_CYCLES = 1024,
   localparam int        GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int        CW             = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           byte_out_data,
   output logic                 byte_out_valid,
   input  logic                 byte_out_ready,
   output logic [GW-1:0]        grant_idx,
   output logic                 busy,
   output logic                 timeout_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   state_t        state;
   logic [GW-1:0] grant;
   logic [GW-1:0] rr_ptr;
   logic [CW-1:0] stall_cnt;
   logic [GW-1:0] pick;
   logic [GW-1:0] cand;
   logic          gvalid;
   logic          glast;
   logic          to_hit;

   function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return GW'(s);
   endfunction

   // Scan from farthest to nearest so the closest candidate after rr_ptr wins.
   always_comb begin
      pick = rr_ptr;
      cand = rr_ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = wrap_idx(rr_ptr, k);
         if (req_valid[cand]) pick = cand;
      end
   end

   assign gvalid = req_valid[grant];
   assign glast  = req_last[grant];
   // Fires on the stall cycle that would bring the counter to TIMEOUT_CYCLES.
   assign to_hit = (TIMEOUT_CYCLES != 0) && (state == ST_STREAM) && !gvalid &&
                   (stall_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         rr_ptr    <= GW'(NUM_REQ - 1);
         stall_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               stall_cnt <= '0;
               if (|req_valid) begin
                  grant  <= pick;
                  rr_ptr <= pick;
                  state  <= INSERT_ID ? ST_HEADER : ST_STREAM;
               end
            end
            ST_HEADER: begin
               if (byte_out_ready) state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (gvalid) begin
                  stall_cnt <= '0;
                  if (byte_out_ready && glast) state <= ST_IDLE;
               end else if (to_hit) begin
                  stall_cnt <= '0;
                  state     <= ST_IDLE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      byte_out_data  = '0;
      byte_out_valid = 1'b0;
      case (state)
         ST_HEADER: begin
            byte_out_data  = ID_BASE + 8'(grant);
            byte_out_valid = 1'b1;
         end
         ST_STREAM: begin
            byte_out_data  = req_data[{grant, 3'b000} +: 8];
            byte_out_valid = gvalid;
         end
         default: ;
      endcase
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
      assign req_ready[i] = (state == ST_STREAM) && (grant == GW'(i)) && byte_out_ready;
   end

   assign grant_idx     = (state == ST_IDLE) ? '0 : grant;
   assign busy          = (state != ST_IDLE);
   assign timeout_pulse = to_hit;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Frame-level round-robin arbiter that shares one uart_tx byte stream among NUM_REQ requesters.
- Each requester presents bytes with valid/ready/last. The grant is held until the last byte of a frame is accepted.
- Optionally prepends a one-byte requester-ID header to every frame so the far end can demultiplex.
- Sits between on-chip byte producers (debug, status, loopback) and the uart_tx byte_in port.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 1..16.
- INSERT_ID, 1: 1 = emit header byte (ID_BASE + granted index) before each frame; 0 = no header.
- ID_BASE, 8'h80: base value of the header byte; the addition wraps modulo 256.
- TIMEOUT_CYCLES, 1024: stall limit mid-frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_data  input  NUM_REQ*8  requester i byte in bits [8*i+7:8*i]
- req_valid  input  NUM_REQ  per-requester byte valid
- req_last  input  NUM_REQ  per-requester marker for the final byte of a frame
- req_ready  output  NUM_REQ  per-requester accept
- byte_out_data  output  8  byte to uart_tx byte_in_data
- byte_out_valid  output  1  to uart_tx byte_in_valid
- byte_out_ready  input  1  from uart_tx byte_in_ready
- grant_idx  output  max(1,$clog2(NUM_REQ))  currently granted requester; 0 when idle
- busy  output  1  high in HEADER or STREAM
- timeout_pulse  output  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Handshake: a transfer occurs on a rising clk edge where valid && ready on that port.
- State machine: IDLE, HEADER, STREAM. All state is registered; outputs are combinational from state.
- Reset (rst high at a clk edge):
  - state <= IDLE; rr_ptr <= NUM_REQ-1, so req 0 has first priority; stall counter <= 0.
  - Outputs from the following cycle: byte_out_valid=0, req_ready=0, grant_idx=0, busy=0, timeout_pulse=0.
  - Reset mid-frame abandons the frame silently; no pulse is generated.
- IDLE:
  - byte_out_valid=0, req_ready=0.
  - If any req_valid is high, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register it into grant and rr_ptr. Next state is HEADER if INSERT_ID=1, else STREAM.
  - Grant is decided on req_valid only; req_last is ignored in IDLE.
- HEADER:
  - byte_out_data = ID_BASE + grant; byte_out_valid=1; req_ready=0.
  - valid is held until byte_out_ready; on the handshake, go to STREAM.
  - The header is never subject to timeout.
- STREAM:
  - byte_out_data = req_data[grant]; byte_out_valid = req_valid[grant].
  - req_ready[grant] = byte_out_ready; all other req_ready bits are 0.
  - A handshake with req_last[grant]=1 goes to IDLE.
- Latency:
  - Request first high in IDLE at edge N produces header valid during cycle N+1. With INSERT_ID=0, the first data byte is visible in cycle N+1.
  - One mandatory IDLE bubble cycle separates consecutive frames.
- Timeout:
  - In STREAM, the counter increments each cycle req_valid[grant]=0 and clears on any cycle req_valid[grant]=1.
  - When the counter reaches TIMEOUT_CYCLES: timeout_pulse=1 for one cycle, state <= IDLE, counter <= 0.
  - rr_ptr keeps the abandoned index, so the next arbitration starts after it.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Fairness:
  - A requester holding valid continuously gets at most one frame before every other valid requester gets one.
  - With a single active requester, it is regranted after each bubble.
- Requester contract: hold data, valid and last stable until ready. Ungranted requesters see ready=0 indefinitely.
- grant_idx equals the registered grant in HEADER/STREAM and is 0 in IDLE. busy = (state != IDLE).
- NUM_REQ=1: arbitration degenerates to always req 0; grant_idx is a 1-bit constant 0.

Test Plan:
- NUM_REQ=4, INSERT_ID=1, ready tied high. Req 2 sends 3-byte frame 8'h11,8'h22,8'h33 (last on 8'h33) -> out stream 8'h82,8'h11,8'h22,8'h33. busy high exactly 4 cycles. One idle cycle afterwards.
- Reqs 0,1,3 all valid continuously, each sending 2-byte frames -> frame order 0,1,3,0,1,3. Headers 8'h80,8'h81,8'h83 repeat. No requester is granted twice in a row.
- Backpressure: ready toggles 1-0-1-0 during a frame from req 1 -> every byte appears exactly once. byte_out_data is stable while valid && !ready. req_ready[1] mirrors ready; all other req_ready bits stay 0.
- TIMEOUT_CYCLES=8. Req 0 sends one byte without last, then drops valid -> timeout_pulse high exactly once, 8 cycles after the last valid cycle. State returns to IDLE. A pending req 1 is granted next, with header 8'h81.
- Assert rst for 1 cycle mid-frame (after header plus 1 byte) -> next cycle byte_out_valid=0, busy=0, no timeout_pulse. After release, req 0 wins first even if req 0 and req 3 are valid together.
- INSERT_ID=0, NUM_REQ=1: 1-byte frames 8'hA5 back-to-back -> output 8'hA5 in alternating cycles (bubble). No header bytes; grant_idx stays 0.
